// File: rtl/tb_stream_controller_if.sv
// Row/column stream and transpose-array bundle for tb_stream_controller.
// master = surrounding datapath (fetch unit, array, interpolator); slave = controller.
interface tb_stream_controller_if #(
    parameter int N         = 8,
    parameter int DATAWIDTH = 8
);
    logic [N*DATAWIDTH-1:0] row_data;
    logic                   row_valid;
    logic                   row_ready;
    logic [N*DATAWIDTH-1:0] tb_in;
    logic                   tb_enable;
    logic                   tb_direction;
    logic [N*DATAWIDTH-1:0] tb_out;
    logic [N*DATAWIDTH-1:0] col_data;
    logic                   col_valid;
    logic                   col_ready;
    logic                   col_last;

    modport master (
        output row_data, row_valid, col_ready, tb_out,
        input  row_ready, tb_in, tb_enable, tb_direction, col_data, col_valid, col_last
    );

    modport slave (
        input  row_data, row_valid, col_ready, tb_out,
        output row_ready, tb_in, tb_enable, tb_direction, col_data, col_valid, col_last
    );
endinterface

// File: rtl/tb_stream_controller.sv
// Fill/drain sequencer for the FME 8x8 transpose buffer array.
// Optional FME_TB_CTRL_PERF_EN adds stall_clr input and a saturating stall_cnt output.
module tb_stream_controller #(
    parameter int DATAWIDTH = 8,
    parameter int N         = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
`ifdef FME_TB_CTRL_PERF_EN
    input  logic                    stall_clr,
    output logic [15:0]             stall_cnt,
`endif
    tb_stream_controller_if.slave   bus,
    output logic                    busy,
    output logic                    block_done
);
    localparam logic [2:0] LAST = 3'(N - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t     state, state_next;
    logic [2:0] row_cnt, row_cnt_next;
    logic [2:0] col_cnt, col_cnt_next;
    logic       done_next;
    logic       row_xfer, col_xfer;

    // Pixel lanes pass straight through; the array does the actual transpose.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign bus.tb_in[i*DATAWIDTH +: DATAWIDTH]    = bus.row_data[i*DATAWIDTH +: DATAWIDTH];
        assign bus.col_data[i*DATAWIDTH +: DATAWIDTH] = bus.tb_out[i*DATAWIDTH +: DATAWIDTH];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            row_cnt    <= 3'd0;
            col_cnt    <= 3'd0;
            block_done <= 1'b0;
        end else begin
            state      <= state_next;
            row_cnt    <= row_cnt_next;
            col_cnt    <= col_cnt_next;
            block_done <= done_next;
        end
    end

    always_comb begin
        state_next       = state;
        row_cnt_next     = row_cnt;
        col_cnt_next     = col_cnt;
        done_next        = 1'b0;
        row_xfer         = 1'b0;
        col_xfer         = 1'b0;
        bus.row_ready    = 1'b0;
        bus.col_valid    = 1'b0;
        bus.col_last     = 1'b0;
        bus.tb_enable    = 1'b0;
        bus.tb_direction = 1'b0;
        case (state)
            FILL: begin
                bus.row_ready = 1'b1;
                row_xfer      = bus.row_valid && !flush;
                // Reset forces FILL asynchronously, so only the strobe needs gating here.
                bus.tb_enable = row_xfer && reset;
                if (row_xfer) begin
                    if (row_cnt == LAST) begin
                        row_cnt_next = 3'd0;
                        state_next   = DRAIN;
                    end else begin
                        row_cnt_next = row_cnt + 3'd1;
                    end
                end
            end
            DRAIN: begin
                bus.col_valid    = 1'b1;
                bus.tb_direction = 1'b1;
                bus.col_last     = (col_cnt == LAST);
                col_xfer         = bus.col_ready && !flush;
                bus.tb_enable    = col_xfer;
                if (col_xfer) begin
                    if (col_cnt == LAST) begin
                        col_cnt_next = 3'd0;
                        state_next   = FILL;
                        done_next    = 1'b1;
                    end else begin
                        col_cnt_next = col_cnt + 3'd1;
                    end
                end
            end
            default: state_next = FILL;
        endcase
        // Abort wins over any handshake; array contents are left for the next block to overwrite.
        if (flush) begin
            state_next   = FILL;
            row_cnt_next = 3'd0;
            col_cnt_next = 3'd0;
            done_next    = 1'b0;
        end
    end

    assign busy = (row_cnt != 3'd0) || (state == DRAIN);

`ifdef FME_TB_CTRL_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (stall_clr) begin
            stall_cnt <= 16'd0;
        end else if (state == DRAIN && !bus.col_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif
endmodule

// File: tb/tb_tb_stream_controller.sv
// Self-checking bench for tb_stream_controller: queue-based transpose model plus a
// behavioural model of the 8x8 array driving tb_out.
module tb_tb_stream_controller;
    localparam int DW = 8;
    localparam int N  = 8;
    localparam int W  = N * DW;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic busy;
    logic block_done;
`ifdef FME_TB_CTRL_PERF_EN
    logic        stall_clr = 1'b0;
    logic [15:0] stall_cnt;
    logic [15:0] stall_exp = 16'd0;
`endif

    tb_stream_controller_if #(.N(N), .DATAWIDTH(DW)) bus ();

    tb_stream_controller #(.DATAWIDTH(DW), .N(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
`ifdef FME_TB_CTRL_PERF_EN
        .stall_clr  (stall_clr),
        .stall_cnt  (stall_cnt),
`endif
        .bus        (bus),
        .busy       (busy),
        .block_done (block_done)
    );

    always #5 clock = ~clock;

    // Array model: rows shift in toward index 0, columns shift out of lane 0.
    logic [W-1:0] arr [N];
    logic [W-1:0] arr_out;

    always @(posedge clock) begin
        if (bus.tb_enable === 1'b1) begin
            if (bus.tb_direction === 1'b0) begin
                for (int r = 0; r < N - 1; r++) arr[r] <= arr[r+1];
                arr[N-1] <= bus.tb_in;
            end else begin
                for (int r = 0; r < N; r++) arr[r] <= arr[r] >> DW;
            end
        end
    end

    always_comb begin
        arr_out = '0;
        for (int i = 0; i < N; i++) arr_out[i*DW +: DW] = arr[i][DW-1:0];
        bus.tb_out = arr_out;
    end

    // Reference model: accepted rows of the open block, and columns still owed.
    logic [W-1:0] rows [$];
    logic [W-1:0] cols [$];
    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    int done_cnt = 0;
    int done_at = 0;
    int en_load = 0;
    int en_read = 0;
    bit last_acc = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic void build_cols();
        logic [W-1:0] c;
        logic [W-1:0] r;
        for (int k = 0; k < N; k++) begin
            c = '0;
            for (int i = 0; i < N; i++) begin
                r = rows[i];
                c[i*DW +: DW] = r[k*DW +: DW];
            end
            cols.push_back(c);
        end
        rows.delete();
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] v;
        v = {$urandom, $urandom};
        return v;
    endfunction

    // Called at posedge+1 after inputs are set; checks this cycle and advances one clock.
    task automatic tick();
        bit drain, acc, xfer, dn;
        logic [W-1:0] rd;
        logic exp_en;
`ifdef FME_TB_CTRL_PERF_EN
        logic [15:0] sn;
`endif
        #1;
        drain  = (cols.size() != 0);
        exp_en = (!reset || flush) ? 1'b0 : (drain ? bus.col_ready : bus.row_valid);
        chk("row_ready", bus.row_ready, !drain);
        chk("col_valid", bus.col_valid, drain);
        chk("tb_direction", bus.tb_direction, drain);
        chk("tb_enable", bus.tb_enable, exp_en);
        chk("col_last", bus.col_last, drain && cols.size() == 1);
        chk("busy", busy, drain || rows.size() != 0);
        if (drain) chk("col_data", bus.col_data, cols[0]);
        acc  = reset && !flush && !drain && bus.row_valid;
        xfer = reset && !flush && drain && bus.col_ready;
        dn   = xfer && cols.size() == 1;
        rd   = bus.row_data;
        if (bus.tb_enable === 1'b1) begin
            if (bus.tb_direction === 1'b1) en_read++;
            else en_load++;
        end
`ifdef FME_TB_CTRL_PERF_EN
        if (stall_clr) sn = 16'd0;
        else if (reset && drain && !bus.col_ready && stall_exp != 16'hFFFF) sn = stall_exp + 16'd1;
        else sn = stall_exp;
`endif
        @(posedge clock);
        #1;
        ncyc++;
        if (flush || !reset) begin
            rows.delete();
            cols.delete();
        end
        if (acc) begin
            rows.push_back(rd);
            if (rows.size() == N) build_cols();
        end
        if (xfer) void'(cols.pop_front());
        last_acc = acc;
        chk("block_done", block_done, dn);
        if (block_done === 1'b1) begin
            done_cnt++;
            done_at = ncyc;
        end
`ifdef FME_TB_CTRL_PERF_EN
        stall_exp = reset ? sn : 16'd0;
        chk("stall_cnt", stall_cnt, stall_exp);
`endif
    endtask

    task automatic send_rows(input int n, input int vld_pct);
        int idx = 0;
        int guard = 0;
        logic [W-1:0] cur;
        cur = rand_row();
        while (idx < n && guard < 300) begin
            bus.row_valid = ($urandom_range(99) < vld_pct);
            bus.row_data  = cur;
            tick();
            if (last_acc) begin
                idx++;
                cur = rand_row();
            end
            guard++;
        end
        bus.row_valid = 1'b0;
        chk("send_rows_timeout", idx, n);
    endtask

    task automatic drain_cols(input int rdy_pct);
        int guard = 0;
        while (cols.size() != 0 && guard < 300) begin
            bus.col_ready = ($urandom_range(99) < rdy_pct);
            tick();
            guard++;
        end
        chk("drain_timeout", cols.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", ncyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int start, d0, nacc, guard;
        logic [W-1:0] snap;
        logic [W-1:0] v;
        logic [W-1:0] blk [16];

        bus.row_valid = 1'b1;
        bus.row_data  = '0;
        bus.col_ready = 1'b1;

        // Reset state, with row_valid high to show tb_enable is held off.
        @(posedge clock);
        #1;
        chk("rst_row_ready", bus.row_ready, 1'b1);
        chk("rst_col_valid", bus.col_valid, 1'b0);
        chk("rst_col_last", bus.col_last, 1'b0);
        chk("rst_tb_enable", bus.tb_enable, 1'b0);
        chk("rst_tb_direction", bus.tb_direction, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_block_done", block_done, 1'b0);
        bus.row_valid = 1'b0;
        reset = 1'b1;
        tick();

        // 1: counting pattern, no backpressure.
        en_load = 0;
        en_read = 0;
        start   = ncyc;
        bus.col_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            for (int i = 0; i < N; i++) v[i*DW +: DW] = 8'(8 * r + i);
            bus.row_valid = 1'b1;
            bus.row_data  = v;
            tick();
        end
        bus.row_valid = 1'b0;
        drain_cols(100);
        chk("t1_load_pulses", en_load, 8);
        chk("t1_read_pulses", en_read, 8);
        chk("t1_done_cycle", done_at - start, 16);

        // 2: five-cycle stall after the first column.
`ifdef FME_TB_CTRL_PERF_EN
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
`endif
        send_rows(N, 100);
        bus.col_ready = 1'b1;
        tick();
        snap = bus.col_data;
        bus.col_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            chk("t2_hold_data", bus.col_data, snap);
            chk("t2_hold_valid", bus.col_valid, 1'b1);
        end
`ifdef FME_TB_CTRL_PERF_EN
        chk("t2_stall_cnt", stall_cnt, 16'd5);
`endif
        drain_cols(100);

        // 3: rows offered throughout the drain.
        send_rows(N, 100);
        bus.row_valid = 1'b1;
        bus.row_data  = rand_row();
        drain_cols(60);
        bus.col_ready = 1'b0;
        #1;
        chk("t3_resume_ready", bus.row_ready, 1'b1);
        chk("t3_resume_enable", bus.tb_enable, 1'b1);
        tick();
        send_rows(N - 1, 100);
        drain_cols(70);

        // 4: flush after four rows with a row offered in the same cycle.
        send_rows(4, 100);
        flush = 1'b1;
        bus.row_valid = 1'b1;
        bus.row_data  = rand_row();
        tick();
        flush = 1'b0;
        bus.row_valid = 1'b0;
        #1;
        chk("t4_busy", busy, 1'b0);
        chk("t4_row_ready", bus.row_ready, 1'b1);
        tick();
        send_rows(N, 80);
        drain_cols(70);

        // 5: asynchronous reset three columns into the drain.
        send_rows(N, 100);
        bus.col_ready = 1'b1;
        repeat (3) tick();
        d0 = done_cnt;
        bus.row_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("t5_col_valid", bus.col_valid, 1'b0);
        chk("t5_row_ready", bus.row_ready, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_tb_enable", bus.tb_enable, 1'b0);
        rows.delete();
        cols.delete();
`ifdef FME_TB_CTRL_PERF_EN
        stall_exp = 16'd0;
`endif
        repeat (2) tick();
        bus.row_valid = 1'b0;
        reset = 1'b1;
        repeat (5) tick();
        chk("t5_no_done", done_cnt, d0);

        // 6: two back-to-back blocks with random gaps on both streams.
        for (int b = 0; b < 16; b++) blk[b] = rand_row();
        d0    = done_cnt;
        nacc  = 0;
        guard = 0;
        while ((nacc < 16 || cols.size() != 0) && guard < 600) begin
            bus.row_valid = (nacc < 16) && ($urandom_range(99) < 70);
            bus.row_data  = blk[nacc % 16];
            bus.col_ready = ($urandom_range(99) < 60);
            tick();
            if (last_acc) nacc++;
            guard++;
        end
        bus.row_valid = 1'b0;
        chk("t6_rows_taken", nacc, 16);
        chk("t6_block_done_count", done_cnt - d0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
